// File: rtl/mux2_rr_arbiter_pkg.sv
// Package: mux2_arb_pkg
// Purpose: shared types and constants for the two-input round-robin arbiter.
//   arb_state_t  - arbiter FSM states (IDLE, GRANT0, GRANT1)
//   LAST_RESET   - reset value of the fairness pointer (1 => input 0 wins first tie)
//   cnt_width()  - width of a counter that must hold 0..max_burst
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic LAST_RESET = 1'b1;

    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_out_reg.sv
// Module: mux2_out_reg
// Purpose: registered output stage of the arbiter. Loads a beat when the
//   arbiter reports a transfer, drains when downstream accepts without a new
//   load, and holds data/valid while downstream stalls.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load       in   a transfer is happening this cycle
//   load_data  in   payload of the transferring beat
//   out_ready  in   downstream accepts the current beat
//   out_valid  out  registered beat valid
//   out_data   out  registered beat payload
module mux2_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    // The arbiter only raises load when the slot is free or being drained,
    // so a load never overwrites a stalled beat.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Module: mux2_rr_arbiter
// Purpose: two-input round-robin stream arbiter feeding a 2:1 select mux.
//   Grants one input at a time for bursts of up to MAX_BURST beats, drives
//   the mux select and registers the winning beat.
// Ports:
//   clk, rst               clock / asynchronous active-high reset
//   in0_valid/data/ready   input 0 stream (ready is combinational)
//   in1_valid/data/ready   input 1 stream (ready is combinational)
//   out_valid/data/ready   registered output stream
//   sel                    mux select, 1 while input 1 is granted
//   busy                   high while either input holds the grant
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy
);

    localparam int CNT_W = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              slot_free;
    logic              grant_valid;
    logic              xfer;
    logic [DATA_W-1:0] grant_data;

    // The output slot can take a beat when empty or being drained this cycle.
    assign slot_free = !out_valid || out_ready;
    assign in0_ready = (state_q == GRANT0) && slot_free;
    assign in1_ready = (state_q == GRANT1) && slot_free;

    assign grant_valid = (state_q == GRANT1) ? in1_valid : in0_valid;
    assign grant_data  = (state_q == GRANT1) ? in1_data  : in0_data;
    assign xfer        = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    // IDLE spends one bubble cycle choosing a winner; a grant ends after the
    // last beat of a burst or as soon as the grantee has nothing to send.
    // A stalled grantee that still holds valid keeps its grant.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (in0_valid) begin
                    state_d = GRANT0;
                end else if (in1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if ((xfer && cnt_q == CNT_LAST) || !grant_valid) begin
                    state_d = IDLE;
                    last_d  = (state_q == GRANT1);
                    cnt_d   = '0;
                end else if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= LAST_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel  = (state_q == GRANT1);
    assign busy = (state_q != IDLE);

    mux2_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (xfer),
        .load_data (grant_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule
